// File: rtl/serial_pkg.sv
// Shared state type, line levels and counter-width helper for the serial transmitter.
package serial_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL   = 1'b0;
  localparam logic STOP_LEVEL    = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Down-counter that measures one bit period; Done marks the final cycle of the period.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic Load,
  output logic Done
);

  localparam int CNT_W = clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Load lands on the edge that starts a bit, so the first cycle of a bit already sees RELOAD.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      count <= '0;
    end else if (Load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign Done = (count == '0);

endmodule

// File: rtl/serial_tx.sv
// Framed LSB-first serial transmitter: start bit, DATA_W data bits, STOP_BITS stop bits.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] Data,
  input  logic              Valid,
  output logic              Ready,
  output logic              Tx,
  output logic              Busy
);

  localparam int IDX_W  = clog2(DATA_W) + 1;
  localparam int STOP_W = clog2(STOP_BITS) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]  bit_idx;
  logic [STOP_W-1:0] stop_cnt;
  logic              accept;
  logic              load;
  logic              bit_done;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .Clk   (Clk),
    .Resetn(Resetn),
    .Load  (load),
    .Done  (bit_done)
  );

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The timer is reloaded on every edge that enters a new bit; leaving STOP for IDLE needs no reload.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (Valid) begin
          accept     = 1'b1;
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          load       = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          load = 1'b1;
          if (bit_idx == LAST_IDX) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (stop_cnt == LAST_STOP) state_next = IDLE;
          else load = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      stop_cnt  <= '0;
    end else if (accept) begin
      shift_reg <= Data;
      bit_idx   <= '0;
      stop_cnt  <= '0;
    end else if (bit_done) begin
      if (state == DATA) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + IDX_W'(1);
      end
      if (state == STOP) begin
        stop_cnt <= stop_cnt + STOP_W'(1);
      end
    end
  end

  always_comb begin
    Tx = TX_IDLE_LEVEL;
    case (state)
      START:   Tx = START_LEVEL;
      DATA:    Tx = shift_reg[0];
      STOP:    Tx = STOP_LEVEL;
      default: Tx = TX_IDLE_LEVEL;
    endcase
  end

  assign Ready = (state == IDLE);
  assign Busy  = (state != IDLE);

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three parameter sets checked every cycle against a frame-position model,
// plus directed frames with hand-computed bit sequences.
`timescale 1ns/1ps
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic [2:0] tx_v;
  logic [2:0] ready_v;
  logic [2:0] busy_v;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  int dw  [3] = '{8, 8, 1};
  int cpb [3] = '{4, 1, 1};
  int sb  [3] = '{1, 2, 1};
  int rem [3] = '{0, 0, 0};
  logic [7:0] word [3];

  logic a5_seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  logic c3_seq [8]  = '{0, 0, 1, 1, 1, 1, 0, 0};
  logic f1_seq [10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
  logic f2_seq [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  logic f0f_seq[10] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .Clk(clk), .Resetn(resetn), .Data(data), .Valid(valid),
    .Ready(ready_v[0]), .Tx(tx_v[0]), .Busy(busy_v[0])
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
    .Clk(clk), .Resetn(resetn), .Data(data), .Valid(valid),
    .Ready(ready_v[1]), .Tx(tx_v[1]), .Busy(busy_v[1])
  );

  serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1), .STOP_BITS(1)) dut_c (
    .Clk(clk), .Resetn(resetn), .Data(data[0:0]), .Valid(valid),
    .Ready(ready_v[2]), .Tx(tx_v[2]), .Busy(busy_v[2])
  );

  function automatic int frame_len(input int i);
    return (1 + dw[i] + sb[i]) * cpb[i];
  endfunction

  // Expected line level from how far into the frame we are, in whole bit periods.
  function automatic logic exp_tx(input int i);
    int pos;
    if (rem[i] == 0) return 1'b1;
    pos = (frame_len(i) - rem[i]) / cpb[i];
    if (pos == 0) return 1'b0;
    if (pos <= dw[i]) return word[i][pos-1];
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic v, input logic [7:0] d);
    @(negedge clk);
    resetn = rst_n;
    valid  = v;
    data   = d;
  endtask

  // rem counts cycles left in the frame, including the current one; zero means idle.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!resetn) begin
        rem[i] = 0;
      end else if (rem[i] == 0) begin
        if (valid) begin
          rem[i]  = frame_len(i);
          word[i] = data;
        end
      end else begin
        rem[i] = rem[i] - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("model_tx%0d", i), 32'(tx_v[i]), 32'(exp_tx(i)));
        checkOutput($sformatf("model_ready%0d", i), 32'(ready_v[i]), 32'(rem[i] == 0));
        checkOutput($sformatf("model_busy%0d", i), 32'(busy_v[i]), 32'(rem[i] != 0));
      end
    end
  end

  initial begin
    int busy_cnt;
    int busy_b;
    int busy_c;

    $display("[TB] reset then idle");
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    check_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checkOutput("idle_tx", 32'(tx_v[0]), 32'd1);
      checkOutput("idle_ready", 32'(ready_v[0]), 32'd1);
      checkOutput("idle_busy", 32'(busy_v[0]), 32'd0);
    end

    $display("[TB] single frame 8'hA5");
    applyStimulus(1'b1, 1'b1, 8'hA5);
    applyStimulus(1'b1, 1'b0, 8'h00);
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      busy_cnt += int'(busy_v[0]);
      if (c == 0) checkOutput("a5_ready_low", 32'(ready_v[0]), 32'd0);
      if (c % 4 == 1) checkOutput($sformatf("a5_bit%0d", c / 4), 32'(tx_v[0]), 32'(a5_seq[c/4]));
    end
    @(negedge clk);
    checkOutput("a5_busy_cycles", 32'(busy_cnt), 32'd40);
    checkOutput("a5_ready_back", 32'(ready_v[0]), 32'd1);
    checkOutput("a5_busy_end", 32'(busy_v[0]), 32'd0);

    $display("[TB] ignored request during 8'h3C");
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'h3C);
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 16) begin
        valid = 1'b1;
        data  = 8'hFF;
      end
      if (c == 20) valid = 1'b0;
      if (c % 4 == 1 && c / 4 >= 1 && c / 4 <= 8)
        checkOutput($sformatf("3c_bit%0d", c / 4 - 1), 32'(tx_v[0]), 32'(c3_seq[c/4-1]));
    end
    repeat (20) begin
      @(negedge clk);
      checkOutput("3c_no_second_frame", 32'(busy_v[0]), 32'd0);
    end

    $display("[TB] back-to-back 8'h01 then 8'h80");
    applyStimulus(1'b1, 1'b1, 8'h01);
    @(negedge clk);
    data = 8'h80;
    for (int c = 0; c <= 80; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 44) valid = 1'b0;
      if (c < 40 && c % 4 == 1)
        checkOutput($sformatf("b2b_f1_bit%0d", c / 4), 32'(tx_v[0]), 32'(f1_seq[c/4]));
      if (c == 40) begin
        checkOutput("b2b_gap_ready", 32'(ready_v[0]), 32'd1);
        checkOutput("b2b_gap_tx", 32'(tx_v[0]), 32'd1);
      end
      if (c == 41) begin
        checkOutput("b2b_f2_start_ready", 32'(ready_v[0]), 32'd0);
        checkOutput("b2b_f2_start_tx", 32'(tx_v[0]), 32'd0);
      end
      if (c >= 41 && (c - 41) % 4 == 1)
        checkOutput($sformatf("b2b_f2_bit%0d", (c - 41) / 4), 32'(tx_v[0]), 32'(f2_seq[(c-41)/4]));
    end

    $display("[TB] reset mid-frame of 8'h55");
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'h55);
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 17) resetn = 1'b0;
    end
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("rst_mid_tx", 32'(tx_v[0]), 32'd1);
    checkOutput("rst_mid_ready", 32'(ready_v[0]), 32'd1);
    checkOutput("rst_mid_busy", 32'(busy_v[0]), 32'd0);
    repeat (10) begin
      @(negedge clk);
      checkOutput("rst_no_resume", 32'(busy_v[0]), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 8'h0F);
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 4 == 1) checkOutput($sformatf("0f_bit%0d", c / 4), 32'(tx_v[0]), 32'(f0f_seq[c/4]));
    end

    $display("[TB] parameter corners");
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    busy_b = 0;
    busy_c = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      busy_b += int'(busy_v[1]);
      busy_c += int'(busy_v[2]);
      if (c < 9) checkOutput($sformatf("cpb1_tx%0d", c), 32'(tx_v[1]), 32'd0);
      else if (c < 11) checkOutput($sformatf("cpb1_tx%0d", c), 32'(tx_v[1]), 32'd1);
      else checkOutput("cpb1_ready_back", 32'(ready_v[1]), 32'd1);
      if (c < 2) checkOutput($sformatf("dw1_tx%0d", c), 32'(tx_v[2]), 32'd0);
      else if (c == 2) checkOutput("dw1_stop", 32'(tx_v[2]), 32'd1);
    end
    checkOutput("cpb1_frame_len", 32'(busy_b), 32'd11);
    checkOutput("dw1_frame_len", 32'(busy_c), 32'd3);

    $display("[TB] randomised traffic");
    repeat (400) begin
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 2) == 0, 8'($urandom));
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Serial transmitter that converts a parallel word into a framed, LSB-first bit stream on a single line.
- Frame is one start bit (0), DATA_W data bits, then STOP_BITS stop bits (1).
- Partner block of the team's D flip-flop and latch storage elements: it produces the serial D stream that flip-flop-based receivers sample.
- Sits between a parallel producer, using a Valid/Ready handshake, and the Tx pin.

Parameters:
- DATA_W, 8: data bits per frame; legal range 1..16.
- CLKS_PER_BIT, 4: Clk cycles each bit is held on Tx; must be >= 1.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- Clk, input, 1: single system clock; all state changes on its rising edge.
- Resetn, input, 1: synchronous, active-low reset, sampled on rising Clk.
- Data, input, DATA_W: word to transmit; sampled only on handshake.
- Valid, input, 1: producer asserts when Data is valid.
- Ready, output, 1: transmitter can accept a word this cycle.
- Tx, output, 1: serial line; idles high.
- Busy, output, 1: high while a frame is in progress (START, DATA or STOP).

Behaviour:
- Reset (Resetn=0 at a rising edge): state=IDLE, Tx=1, Ready=1, Busy=0, shift register and counters cleared.
- All outputs are registered or decoded from registered state only; none combinationally depends on Valid or Data.
- States and transitions:
  - IDLE: Ready=1, Busy=0, Tx=1. If Valid=1, latch Data into the shift register and go to START at the next edge.
  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: Tx=shift_reg[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After the bit at index DATA_W-1, go to STOP.
  - STOP: Tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Ready=1 only in IDLE. Busy=1 in START, DATA and STOP.
- Handshake: a transfer occurs on the rising edge where Valid=1 and Ready=1.
  - Valid asserted while Ready=0 is ignored; no queuing.
  - Data changes after the accept edge have no effect on the frame in progress.
- Latency: the first START cycle on Tx is the cycle after the accept edge.
- Frame length is (1+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back frames: after the last stop cycle the block spends exactly one cycle in IDLE with Tx=1 and Ready=1. If Valid is held high, the next start bit begins on the following cycle.
- Bit timer:
  - Down-counter of width clog2(CLKS_PER_BIT)+1, reloaded to CLKS_PER_BIT-1 on each bit entry.
  - The bit ends when the count reaches 0.
  - With CLKS_PER_BIT=1, every bit lasts exactly one cycle.
- Bit index counter: width clog2(DATA_W)+1; it must not wrap before DATA_W bits are sent.
- Stop-bit counter: counts STOP_BITS periods; STOP_BITS=2 produces two consecutive high bit periods.
- Reset mid-frame: at the reset edge the frame is aborted, Tx returns to 1 and state to IDLE. No partial frame resumes after Resetn deasserts.
- Simultaneous Resetn=0 and Valid=1: reset wins and nothing is accepted.

Decomposition:
- Package serial_pkg holds:
  - state enum tx_state_t: IDLE, START, DATA, STOP;
  - constants TX_IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1;
  - function clog2 for counter widths.
- One sub-module, bit_timer:
  - parameter CLKS_PER_BIT;
  - inputs Clk, Resetn, Load;
  - output Done, high in the final cycle of a bit period.
- serial_tx holds the FSM, shift register, bit index and stop counter.

Test Plan:
- Reset then idle (Resetn=0 for 2 cycles, then 1; Valid=0 for 20 cycles): Tx=1, Ready=1 and Busy=0 throughout.
- Single frame (DATA_W=8, CLKS_PER_BIT=4, Data=8'hA5, one-cycle Valid pulse):
  - Tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1;
  - Busy is high for 40 cycles;
  - Ready returns high in cycle 41 after accept.
- Ignored request: Valid=1 with Data=8'hFF mid-frame, while the 8'h3C frame is in DATA: transmitted bits remain 0,0,1,1,1,1,0,0 and no second frame follows.
- Back-to-back (Valid held high, Data=8'h01 then 8'h80): exactly one idle-high cycle between the stop bit of frame 1 and the start bit of frame 2; both frames' bits are correct.
- Reset mid-frame (Resetn=0 for 1 cycle during data bit 3 of 8'h55): Tx=1 and Ready=1 on the cycle after the reset edge; the next accepted 8'h0F frame is correct.
- Parameter corners:
  - CLKS_PER_BIT=1, STOP_BITS=2, Data=8'h00: frame is 11 cycles (0 ×9, then 1,1);
  - DATA_W=1: frame is 3 cycles.
